// File: rtl/local_mem_bank_arbiter.sv
// Two-port arbiter in front of one local-memory bank AVMM port.
// Port 0 carries the host DMA path and port 1 the kernel memory master. Commands are
// round-robin arbitrated and forwarded combinationally. Write bursts keep the grant
// until their last beat. Read responses are steered back through an ordered route FIFO.
module local_mem_bank_arbiter #(
   parameter int unsigned ADDR_WIDTH       = 33,
   parameter int unsigned DATA_WIDTH       = 512,
   parameter int unsigned BURSTCOUNT_WIDTH = 5,
   parameter int unsigned BYTEENABLE_WIDTH = 64,
   parameter int unsigned RSP_FIFO_DEPTH   = 64
) (
   input  logic                        clk,
   input  logic                        reset_n,
   // requester 0
   input  logic [ADDR_WIDTH-1:0]       s0_address,
   input  logic                        s0_read,
   input  logic                        s0_write,
   input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
   input  logic [DATA_WIDTH-1:0]       s0_writedata,
   input  logic [BYTEENABLE_WIDTH-1:0] s0_byteenable,
   output logic                        s0_waitrequest,
   output logic [DATA_WIDTH-1:0]       s0_readdata,
   output logic                        s0_readdatavalid,
   // requester 1
   input  logic [ADDR_WIDTH-1:0]       s1_address,
   input  logic                        s1_read,
   input  logic                        s1_write,
   input  logic [BURSTCOUNT_WIDTH-1:0] s1_burstcount,
   input  logic [DATA_WIDTH-1:0]       s1_writedata,
   input  logic [BYTEENABLE_WIDTH-1:0] s1_byteenable,
   output logic                        s1_waitrequest,
   output logic [DATA_WIDTH-1:0]       s1_readdata,
   output logic                        s1_readdatavalid,
   // bank side
   output logic [ADDR_WIDTH-1:0]       m_address,
   output logic                        m_read,
   output logic                        m_write,
   output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
   output logic [DATA_WIDTH-1:0]       m_writedata,
   output logic [BYTEENABLE_WIDTH-1:0] m_byteenable,
   input  logic                        m_waitrequest,
   input  logic [DATA_WIDTH-1:0]       m_readdata,
   input  logic                        m_readdatavalid,
   output logic                        err_unexpected_rsp
);

   localparam int unsigned PtrW = $clog2(RSP_FIFO_DEPTH);
   localparam int unsigned EntW = 1 + BURSTCOUNT_WIDTH;

   typedef enum logic [0:0] {StIdle, StWrBurst} state_t;

   state_t                      state_q, state_d;
   logic                        rr_last_q, rr_last_d;
   logic                        wr_owner_q, wr_owner_d;
   logic [BURSTCOUNT_WIDTH-1:0] wr_left_q, wr_left_d;

   logic [EntW-1:0]             fifo_mem [RSP_FIFO_DEPTH];
   logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]               fifo_cnt_q;
   logic [BURSTCOUNT_WIDTH-1:0] rd_cnt_q;
   logic                        err_q;

   logic                        fifo_full, fifo_empty;
   logic                        elig0, elig1;
   logic                        gnt_valid, gnt;
   logic                        sel_read, sel_write;
   logic [BURSTCOUNT_WIDTH-1:0] sel_bc, bc_eff;
   logic                        cmd_acc, push, pop, rsp_hit;
   logic [EntW-1:0]             head;
   logic                        head_port;
   logic [BURSTCOUNT_WIDTH-1:0] head_bc;

   assign fifo_full  = (fifo_cnt_q == (PtrW+1)'(RSP_FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt_q == '0);

   // Grant selection: locked to the burst owner, otherwise round-robin among eligible ports.
   always_comb begin
      elig0     = s0_write | (s0_read & ~fifo_full);
      elig1     = s1_write | (s1_read & ~fifo_full);
      gnt_valid = 1'b0;
      gnt       = 1'b0;
      if (state_q == StWrBurst) begin
         gnt_valid = 1'b1;
         gnt       = wr_owner_q;
      end else if (elig0 && elig1) begin
         gnt_valid = 1'b1;
         gnt       = ~rr_last_q;
      end else if (elig0) begin
         gnt_valid = 1'b1;
         gnt       = 1'b0;
      end else if (elig1) begin
         gnt_valid = 1'b1;
         gnt       = 1'b1;
      end
   end

   // Command mux toward the bank; reads are never forwarded during a write burst.
   always_comb begin
      sel_read     = gnt ? s1_read       : s0_read;
      sel_write    = gnt ? s1_write      : s0_write;
      sel_bc       = gnt ? s1_burstcount : s0_burstcount;
      m_address    = gnt ? s1_address    : s0_address;
      m_burstcount = sel_bc;
      m_writedata  = gnt ? s1_writedata  : s0_writedata;
      m_byteenable = gnt ? s1_byteenable : s0_byteenable;
      m_write      = gnt_valid & sel_write;
      m_read       = gnt_valid & (state_q == StIdle) & sel_read & ~sel_write & ~fifo_full;
      bc_eff       = (sel_bc == '0) ? BURSTCOUNT_WIDTH'(1) : sel_bc;
   end

   assign s0_waitrequest = ~(gnt_valid & ~gnt) | m_waitrequest;
   assign s1_waitrequest = ~(gnt_valid &  gnt) | m_waitrequest;
   assign cmd_acc        = (m_read | m_write) & ~m_waitrequest;
   assign push           = m_read & ~m_waitrequest;

   // Response routing from the head of the route FIFO.
   always_comb begin
      head             = fifo_mem[rd_ptr_q];
      head_port        = head[EntW-1];
      head_bc          = head[BURSTCOUNT_WIDTH-1:0];
      rsp_hit          = m_readdatavalid & ~fifo_empty;
      pop              = rsp_hit & (rd_cnt_q == head_bc - BURSTCOUNT_WIDTH'(1));
      s0_readdatavalid = rsp_hit & ~head_port;
      s1_readdatavalid = rsp_hit &  head_port;
   end

   assign s0_readdata        = m_readdata;
   assign s1_readdata        = m_readdata;
   assign err_unexpected_rsp = err_q;

   // Next-state for the arbitration FSM and burst tracking.
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      wr_owner_d = wr_owner_q;
      wr_left_d  = wr_left_q;
      if (cmd_acc) rr_last_d = gnt;
      unique case (state_q)
         StIdle: begin
            if (m_write && !m_waitrequest && (bc_eff > BURSTCOUNT_WIDTH'(1))) begin
               wr_left_d  = bc_eff - BURSTCOUNT_WIDTH'(1);
               wr_owner_d = gnt;
               state_d    = StWrBurst;
            end
         end
         StWrBurst: begin
            if (m_write && !m_waitrequest) begin
               wr_left_d = wr_left_q - BURSTCOUNT_WIDTH'(1);
               if (wr_left_q == BURSTCOUNT_WIDTH'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and arbitration state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         rr_last_q  <= 1'b1;
         wr_owner_q <= 1'b0;
         wr_left_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         wr_owner_q <= wr_owner_d;
         wr_left_q  <= wr_left_d;
      end
   end

   // Route FIFO storage; contents are only read while the occupancy says they are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {gnt, bc_eff};
   end

   // Route FIFO pointers, response beat counter and sticky error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         rd_cnt_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (PtrW+1)'(1);
         else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - (PtrW+1)'(1);
         if (pop)          rd_cnt_q <= '0;
         else if (rsp_hit) rd_cnt_q <= rd_cnt_q + BURSTCOUNT_WIDTH'(1);
         if (m_readdatavalid && fifo_empty) err_q <= 1'b1;
      end
   end

endmodule
